mem_read_arbiter: RTL and testbench
===================================

# mem_read_arbiter

Shares the single 32-bit memory read port among NUM_REQ load requesters (weight/feature fetch units) with round-robin arbitration and one outstanding transaction. Issues word-aligned reads, then sign-extends and aligns the returned word per request size/offset before returning it to the winning requester. Sits between the fetch units and the on-chip memory read port.

## Interface
- NUM_REQ, 4: number of requesters, ≥2.
- ADDR_WIDTH, 32: byte address width.
- ID_WIDTH, $clog2(NUM_REQ): requester index width.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot acceptance; combinational, IDLE only.
- req_addr  in  NUM_REQ*ADDR_WIDTH  byte addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_size  in  NUM_REQ*2  requester i at [i*2 +: 2]: 00 byte, 01 half, 10 word, 11 reserved.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_WIDTH  {addr[ADDR_WIDTH-1:2], 2'b00}.
- mem_ready  in  1  memory accepts mem_req this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  raw word.
- resp_valid  out  1  one-cycle response pulse.
- resp_id  out  ID_WIDTH  index of requester served.
- resp_data  out  32  formatted, sign-extended data.
- resp_err  out  1  misaligned or reserved-size request.

## Operation
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE; error path IDLE → RESP.
- IDLE: if any req_valid, grant first valid index searching ptr+1, ptr+2, … modulo NUM_REQ; req_ready[grant]=1 that cycle; latch addr, size, id; ptr ← id. No valid: stay, req_ready=0.
- Error check at grant: size 11, or half with addr[0]=1, or word with addr[1:0]≠0 → no memory access; go to RESP with resp_err=1, resp_data=0.
- ISSUE: mem_req=1, mem_addr held stable until mem_ready; on mem_ready → WAIT.
- WAIT: on mem_rvalid capture formatted data → RESP. mem_rvalid in any other state ignored.
- Formatting: byte = mem_rdata[offset*8 +: 8] sign-extended; half = offset[1] ? [31:16] : [15:0] sign-extended; word = as is.
- RESP: resp_valid=1, resp_id, resp_data, resp_err registered; → IDLE.
- Reset values: state IDLE, ptr NUM_REQ-1 (requester 0 wins first), mem_req 0, mem_addr 0, resp_valid 0, resp_id 0, resp_data 0, resp_err 0, req_ready 0.
- Reset mid-operation: abandon transaction, no response; late mem_rvalid discarded.

## Timing
- Grant in cycle T (req_ready high); mem_req rises T+1.
- mem_ready at T+1, mem_rvalid at T+2 → resp_valid at T+3: minimum latency 3 cycles grant-to-response.
- Error request: resp_valid at T+1.
- Max throughput one request per 4 cycles; next grant earliest in cycle after RESP.
- Requesters hold req_valid/addr/size until req_ready; req_ready never asserted outside IDLE.
- Round-robin fairness: a continuously valid requester waits at most NUM_REQ-1 grants.

## Structure
- Shared package accel_pkg: size codes SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10; FSM state encodings IDLE/ISSUE/WAIT/RESP (2 bits).
- Sub-module RDataGen instantiated for formatting (fed latched size and addr[1:0]); Encoder instantiated to convert the one-hot grant into resp_id. Round-robin mask/priority logic inline.

## Test plan
- Reset, all req_valid=0 → mem_req=0, resp_valid=0, req_ready=0 for 10 cycles.
- Requester 2, addr 0x103, size byte, mem_rdata 0x80FF_1234 with immediate mem_ready/rvalid → mem_addr 0x100, resp_id 2, resp_data 0xFFFF_FF80, resp_valid 3 cycles after grant.
- All four valid continuously, half-word requests → grant order 0,1,2,3,0; each resp_id matches; offset 2 with rdata 0x7ABC_0000 → 0x0000_7ABC.
- Requester 1, word at addr 0x202 → no mem_req, resp_err=1, resp_data 0, resp_valid 1 cycle after grant; size 11 same result.
- mem_ready held low 5 cycles → mem_req and mem_addr stable; spurious mem_rvalid during ISSUE ignored; response after real rvalid.
- rst_n low in WAIT, then mem_rvalid → no resp_valid; next grant goes to requester 0.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared definitions for the memory read arbiter: access size codes,
// FSM state encoding and the alignment check used at grant time.
package accel_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Reserved size codes are treated as errors just like misalignment.
  function automatic logic isBadAccess(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b1;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_read_arbiter_sub.sv
// Helper blocks for the read arbiter: lane extraction/sign extension of the
// returned memory word, and a one-hot to binary index encoder.
module RDataGen
  import accel_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    byteVal = rdata_i[{offset_i, 3'b000} +: 8];
    halfVal = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o  = '0;
    case (size_i)
      SIZE_BYTE: data_o = {{24{byteVal[7]}}, byteVal};
      SIZE_HALF: data_o = {{16{halfVal[15]}}, halfVal};
      SIZE_WORD: data_o = rdata_i;
      default:   data_o = '0;
    endcase
  end

endmodule

module Encoder #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] oneHot_i,
  output logic [W-1:0] index_o
);

  always_comb begin
    index_o = '0;
    for (int i = 0; i < N; i++) begin
      if (oneHot_i[i]) index_o = index_o | W'(i);
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory read port among NUM_REQ
// requesters, one outstanding read, with size/offset formatting of the data.
module mem_read_arbiter
  import accel_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*2-1:0]        req_size,
  output logic                        mem_req,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [31:0]                 mem_rdata,
  output logic                        resp_valid,
  output logic [ID_WIDTH-1:0]         resp_id,
  output logic [31:0]                 resp_data,
  output logic                        resp_err
);

  state_t                stateQ;
  logic [ID_WIDTH-1:0]   ptrQ;
  logic [ID_WIDTH-1:0]   idQ;
  logic [1:0]            sizeQ;
  logic [1:0]            offsetQ;
  logic                  memReqQ;
  logic [ADDR_WIDTH-1:0] memAddrQ;
  logic                  respValidQ;
  logic [ID_WIDTH-1:0]   respIdQ;
  logic [31:0]           respDataQ;
  logic                  respErrQ;

  logic [NUM_REQ-1:0]    grantOh;
  logic [ID_WIDTH-1:0]   grantId;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [1:0]            selSize;
  logic                  grantErr;
  logic [31:0]           fmtData;

  // First valid requester after the last winner takes the grant.
  always_comb begin
    grantOh = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int cand;
      cand = (int'(ptrQ) + k) % NUM_REQ;
      if (grantOh == '0 && req_valid[cand]) grantOh[cand] = 1'b1;
    end
  end

  Encoder #(.N(NUM_REQ), .W(ID_WIDTH)) uEncoder (
    .oneHot_i (grantOh),
    .index_o  (grantId)
  );

  assign selAddr  = req_addr[int'(grantId)*ADDR_WIDTH +: ADDR_WIDTH];
  assign selSize  = req_size[int'(grantId)*2 +: 2];
  assign grantErr = isBadAccess(selSize, selAddr[1:0]);

  RDataGen uRDataGen (
    .size_i   (sizeQ),
    .offset_i (offsetQ),
    .rdata_i  (mem_rdata),
    .data_o   (fmtData)
  );

  assign req_ready  = (stateQ == IDLE) ? grantOh : '0;
  assign mem_req    = memReqQ;
  assign mem_addr   = memAddrQ;
  assign resp_valid = respValidQ;
  assign resp_id    = respIdQ;
  assign resp_data  = respDataQ;
  assign resp_err   = respErrQ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ     <= IDLE;
      ptrQ       <= ID_WIDTH'(NUM_REQ - 1);
      idQ        <= '0;
      sizeQ      <= SIZE_BYTE;
      offsetQ    <= '0;
      memReqQ    <= 1'b0;
      memAddrQ   <= '0;
      respValidQ <= 1'b0;
      respIdQ    <= '0;
      respDataQ  <= '0;
      respErrQ   <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (grantOh != '0) begin
            ptrQ    <= grantId;
            idQ     <= grantId;
            sizeQ   <= selSize;
            offsetQ <= selAddr[1:0];
            if (grantErr) begin
              // Bad requests skip memory entirely and answer next cycle.
              respValidQ <= 1'b1;
              respIdQ    <= grantId;
              respDataQ  <= '0;
              respErrQ   <= 1'b1;
              stateQ     <= RESP;
            end else begin
              memReqQ  <= 1'b1;
              memAddrQ <= {selAddr[ADDR_WIDTH-1:2], 2'b00};
              stateQ   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            memReqQ <= 1'b0;
            stateQ  <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            respValidQ <= 1'b1;
            respIdQ    <= idQ;
            respDataQ  <= fmtData;
            respErrQ   <= 1'b0;
            stateQ     <= RESP;
          end
        end
        RESP: begin
          respValidQ <= 1'b0;
          stateQ     <= IDLE;
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: reset, byte/half/word formatting,
// round-robin order, error path, memory stalls and reset mid-transaction.
module tb_mem_read_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   reqValid;
  logic [3:0]   reqReady;
  logic [127:0] reqAddr;
  logic [7:0]   reqSize;
  logic         memReq;
  logic [31:0]  memAddr;
  logic         memReady;
  logic         memRvalid;
  logic [31:0]  memRdata;
  logic         respValid;
  logic [1:0]   respId;
  logic [31:0]  respData;
  logic         respErr;

  int vecCount = 0;
  int errCount = 0;

  mem_read_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_addr   (reqAddr),
    .req_size   (reqSize),
    .mem_req    (memReq),
    .mem_addr   (memAddr),
    .mem_ready  (memReady),
    .mem_rvalid (memRvalid),
    .mem_rdata  (memRdata),
    .resp_valid (respValid),
    .resp_id    (respId),
    .resp_data  (respData),
    .resp_err   (respErr)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are observed 1ns after the falling edge.
  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic setReq(input int id, input logic [31:0] addr, input logic [1:0] size);
    reqAddr[id*32 +: 32] = addr;
    reqSize[id*2 +: 2]   = size;
  endtask

  task automatic doReset;
    rst_n = 1'b0;
    reqValid = '0;
    memReady = 1'b0;
    memRvalid = 1'b0;
    step;
    step;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    reqValid = '0;
    reqAddr = '0;
    reqSize = '0;
    memReady = 1'b0;
    memRvalid = 1'b0;
    memRdata = '0;
    step;
    step;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step;
      vecCount++;
      if (memReq !== 1'b0) begin errCount++; $display("[TB] FAIL reset_mem_req cyc%0d: got %b expected 0", c, memReq); end
      vecCount++;
      if (respValid !== 1'b0) begin errCount++; $display("[TB] FAIL reset_resp_valid cyc%0d: got %b expected 0", c, respValid); end
      vecCount++;
      if (reqReady !== 4'b0000) begin errCount++; $display("[TB] FAIL reset_req_ready cyc%0d: got %b expected 0000", c, reqReady); end
    end
    vecCount++;
    if (memAddr !== 32'h0 || respId !== 2'd0 || respData !== 32'h0 || respErr !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL reset_regs: got addr=%h id=%0d data=%h err=%b expected all zero", memAddr, respId, respData, respErr);
    end
  endtask

  task automatic test_byte;
    setReq(2, 32'h0000_0103, 2'b00);
    reqValid = 4'b0100;
    memReady = 1'b1;
    memRvalid = 1'b1;
    memRdata = 32'h80FF_1234;
    #1;
    vecCount++;
    if (reqReady !== 4'b0100) begin errCount++; $display("[TB] FAIL byte_grant: got %b expected 0100", reqReady); end
    step;
    reqValid = '0;
    vecCount++;
    if (memReq !== 1'b1 || memAddr !== 32'h0000_0100) begin
      errCount++;
      $display("[TB] FAIL byte_issue: got req=%b addr=%h expected req=1 addr=00000100", memReq, memAddr);
    end
    step;
    vecCount++;
    if (memReq !== 1'b0 || respValid !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL byte_wait: got req=%b resp_valid=%b expected 0 0", memReq, respValid);
    end
    step;
    vecCount++;
    if (respValid !== 1'b1 || respId !== 2'd2 || respData !== 32'hFFFF_FF80 || respErr !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL byte_resp: got v=%b id=%0d data=%h err=%b expected v=1 id=2 data=ffffff80 err=0",
               respValid, respId, respData, respErr);
    end
    step;
    memRvalid = 1'b0;
    vecCount++;
    if (respValid !== 1'b0) begin errCount++; $display("[TB] FAIL byte_pulse: got %b expected 0", respValid); end
  endtask

  task automatic test_round_robin;
    logic [31:0] addrTab [4];
    logic [31:0] expData;
    int waited;
    int lat;
    addrTab[0] = 32'h0000_0000;
    addrTab[1] = 32'h0000_0012;
    addrTab[2] = 32'h0000_0020;
    addrTab[3] = 32'h0000_0032;
    doReset;
    for (int i = 0; i < 4; i++) setReq(i, addrTab[i], 2'b01);
    memReady = 1'b1;
    memRvalid = 1'b1;
    memRdata = 32'h7ABC_8001;
    reqValid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      waited = 0;
      while (reqReady == 4'b0000 && waited < 10) begin step; waited++; end
      vecCount++;
      if (reqReady !== 4'(1 << (n % 4))) begin
        errCount++;
        $display("[TB] FAIL rr_grant%0d: got %b expected %b", n, reqReady, 4'(1 << (n % 4)));
      end
      expData = (n % 2 == 0) ? 32'hFFFF_8001 : 32'h0000_7ABC;
      step;
      if (n == 4) reqValid = 4'b0000;
      lat = 1;
      while (respValid !== 1'b1 && lat < 10) begin step; lat++; end
      vecCount++;
      if (respValid !== 1'b1 || lat != 3) begin
        errCount++;
        $display("[TB] FAIL rr_latency%0d: got valid=%b after %0d cycles expected valid=1 after 3", n, respValid, lat);
      end
      vecCount++;
      if (respId !== 2'(n % 4) || respData !== expData) begin
        errCount++;
        $display("[TB] FAIL rr_resp%0d: got id=%0d data=%h expected id=%0d data=%h", n, respId, respData, n % 4, expData);
      end
    end
    step;
    memRvalid = 1'b0;
  endtask

  task automatic test_error;
    int          idTab   [3];
    logic [31:0] addrTab [3];
    logic [1:0]  sizeTab [3];
    idTab[0] = 1; addrTab[0] = 32'h0000_0202; sizeTab[0] = 2'b10;
    idTab[1] = 3; addrTab[1] = 32'h0000_0300; sizeTab[1] = 2'b11;
    idTab[2] = 0; addrTab[2] = 32'h0000_0401; sizeTab[2] = 2'b01;
    memReady = 1'b1;
    memRvalid = 1'b0;
    memRdata = 32'hFFFF_FFFF;
    for (int e = 0; e < 3; e++) begin
      setReq(idTab[e], addrTab[e], sizeTab[e]);
      reqValid = 4'(1 << idTab[e]);
      #1;
      vecCount++;
      if (reqReady !== 4'(1 << idTab[e])) begin
        errCount++;
        $display("[TB] FAIL err_grant%0d: got %b expected %b", e, reqReady, 4'(1 << idTab[e]));
      end
      step;
      reqValid = '0;
      vecCount++;
      if (respValid !== 1'b1 || respErr !== 1'b1 || respData !== 32'h0 || respId !== 2'(idTab[e]) || memReq !== 1'b0) begin
        errCount++;
        $display("[TB] FAIL err_resp%0d: got v=%b err=%b data=%h id=%0d mem_req=%b expected v=1 err=1 data=0 id=%0d mem_req=0",
                 e, respValid, respErr, respData, respId, memReq, idTab[e]);
      end
      step;
      vecCount++;
      if (respValid !== 1'b0 || memReq !== 1'b0) begin
        errCount++;
        $display("[TB] FAIL err_after%0d: got v=%b mem_req=%b expected 0 0", e, respValid, memReq);
      end
    end
  endtask

  task automatic test_stall;
    setReq(3, 32'h0000_0344, 2'b10);
    memReady = 1'b0;
    memRvalid = 1'b0;
    reqValid = 4'b1000;
    #1;
    vecCount++;
    if (reqReady !== 4'b1000) begin errCount++; $display("[TB] FAIL stall_grant: got %b expected 1000", reqReady); end
    step;
    reqValid = '0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step;
      vecCount++;
      if (memReq !== 1'b1 || memAddr !== 32'h0000_0344 || respValid !== 1'b0) begin
        errCount++;
        $display("[TB] FAIL stall_hold%0d: got req=%b addr=%h v=%b expected req=1 addr=00000344 v=0", k, memReq, memAddr, respValid);
      end
      memRvalid = (k == 3);
      memRdata  = (k == 3) ? 32'hDEAD_BEEF : 32'h0;
    end
    memReady = 1'b1;
    memRvalid = 1'b0;
    step;
    vecCount++;
    if (memReq !== 1'b0 || respValid !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL stall_wait: got req=%b v=%b expected 0 0", memReq, respValid);
    end
    memReady = 1'b0;
    memRvalid = 1'b1;
    memRdata = 32'h1234_5678;
    step;
    memRvalid = 1'b0;
    vecCount++;
    if (respValid !== 1'b1 || respData !== 32'h1234_5678 || respId !== 2'd3 || respErr !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL stall_resp: got v=%b data=%h id=%0d err=%b expected v=1 data=12345678 id=3 err=0",
               respValid, respData, respId, respErr);
    end
    step;
  endtask

  task automatic test_reset_mid;
    int waited;
    setReq(2, 32'h0000_0208, 2'b10);
    memReady = 1'b1;
    memRvalid = 1'b0;
    reqValid = 4'b0100;
    #1;
    vecCount++;
    if (reqReady !== 4'b0100) begin errCount++; $display("[TB] FAIL mid_grant: got %b expected 0100", reqReady); end
    step;
    reqValid = '0;
    step;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    memRvalid = 1'b1;
    memRdata = 32'hCAFE_F00D;
    vecCount++;
    if (memReq !== 1'b0) begin errCount++; $display("[TB] FAIL mid_mem_req: got %b expected 0", memReq); end
    for (int c = 0; c < 4; c++) begin
      step;
      vecCount++;
      if (respValid !== 1'b0) begin errCount++; $display("[TB] FAIL mid_no_resp%0d: got %b expected 0", c, respValid); end
    end
    memRvalid = 1'b0;
    setReq(0, 32'h0000_0000, 2'b10);
    reqValid = 4'b0101;
    #1;
    vecCount++;
    if (reqReady !== 4'b0001) begin errCount++; $display("[TB] FAIL mid_regrant: got %b expected 0001", reqReady); end
    memRvalid = 1'b1;
    memRdata = 32'h0BAD_CAFE;
    step;
    reqValid = '0;
    waited = 1;
    while (respValid !== 1'b1 && waited < 10) begin step; waited++; end
    memRvalid = 1'b0;
    vecCount++;
    if (respValid !== 1'b1 || respId !== 2'd0 || respData !== 32'h0BAD_CAFE) begin
      errCount++;
      $display("[TB] FAIL mid_resp: got v=%b id=%0d data=%h expected v=1 id=0 data=0badcafe", respValid, respId, respData);
    end
    step;
  endtask

  initial begin
    test_reset();
    test_byte();
    test_round_robin();
    test_error();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
